// File: rtl/soc_cpu_mul_pkg.sv
// Shared types and widths for the sequential 32x32 multiply sequencer.
// Used by soc_cpu_4_mul_seq.
package soc_cpu_mul_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P0   = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_DONE = 3'd4
    } mul_state_t;

    // Recombine the two partial products: lo + (hi << 16), truncated to 32 bits.
    function automatic logic [DATA_W-1:0] mul_combine(
        input logic [DATA_W-1:0] part_lo,
        input logic [DATA_W-1:0] part_hi
    );
        return part_lo + (part_hi << HALF_W);
    endfunction

endpackage

// File: rtl/soc_cpu_4_mul_seq.sv
// Sequencer computing (A*B) mod 2^32 with an external 32x16 mult cell, in two half-word passes.
// Optional macro SOC_CPU_MUL_SEQ_SKIP_EN: skip the high pass when B[31:16] is zero.
module soc_cpu_4_mul_seq
    import soc_cpu_mul_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    output logic [DATA_W-1:0] M_mul_src1,
    output logic [DATA_W-1:0] M_mul_src2,
    input  logic [DATA_W-1:0] M_mul_cell_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              busy
);

    mul_state_t        state;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] r0;
    logic              skip_hi;

`ifdef SOC_CPU_MUL_SEQ_SKIP_EN
    assign skip_hi = (op_b[DATA_W-1:HALF_W] == '0);
`else
    assign skip_hi = 1'b0;
`endif

    // Operand mux to the mult cell; idle cycles present zeros so the cell stays quiet.
    always_comb begin
        M_mul_src1 = '0;
        M_mul_src2 = '0;
        case (state)
            ST_P0: begin
                M_mul_src1 = op_a;
                M_mul_src2 = {{HALF_W{1'b0}}, op_b[HALF_W-1:0]};
            end
            ST_P1: begin
                M_mul_src1 = op_a;
                M_mul_src2 = {{HALF_W{1'b0}}, op_b[DATA_W-1:HALF_W]};
            end
            default: begin
                M_mul_src1 = '0;
                M_mul_src2 = '0;
            end
        endcase
    end

    // req_ready and busy are registered so they read 0 throughout reset and
    // req_ready comes up on the first edge after reset_n is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            op_a       <= '0;
            op_b       <= '0;
            r0         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_a      <= req_src1;
                        op_b      <= req_src2;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_P0;
                    end else begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                ST_P0: begin
                    state <= ST_P1;
                end
                ST_P1: begin
                    // The cell now returns the low-half partial product.
                    if (skip_hi) begin
                        rsp_result <= M_mul_cell_result;
                        rsp_valid  <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        r0    <= M_mul_cell_result;
                        state <= ST_P2;
                    end
                end
                ST_P2: begin
                    rsp_result <= mul_combine(r0, M_mul_cell_result);
                    rsp_valid  <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_cpu_4_mul_seq.sv
// Self-checking bench for soc_cpu_4_mul_seq with a behavioural one-cycle 32x16 mult cell.
// Honours SOC_CPU_MUL_SEQ_SKIP_EN when computing expected latency.
module tb_soc_cpu_4_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic [31:0] M_mul_src1;
    logic [31:0] M_mul_src2;
    logic [31:0] M_mul_cell_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        busy;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          scramble;
    } vec_t;

    soc_cpu_4_mul_seq dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_src1          (req_src1),
        .req_src2          (req_src2),
        .M_mul_src1        (M_mul_src1),
        .M_mul_src2        (M_mul_src2),
        .M_mul_cell_result (M_mul_cell_result),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_result        (rsp_result),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Mult cell: (src1 * src2[15:0]) mod 2^32, one cycle after the operands.
    always @(posedge clk) begin
        M_mul_cell_result <= 32'(M_mul_src1 * {16'h0, M_mul_src2[15:0]});
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: handshake, scoreboard push, latency/operand checks,
    // optional rsp_ready back-pressure, then return to IDLE.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                                 input int hold, input bit scramble);
        int          cyc;
        int          exp_lat;
        int          guard;
        logic [31:0] exp_res;
        logic [31:0] held;
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("req_ready_before_op", {31'b0, req_ready}, 32'd1);
        req_src1  = a;
        req_src2  = b;
        req_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        req_valid = 1'b0;
        if (scramble) begin
            req_src1  = $urandom;
            req_src2  = $urandom;
            req_valid = 1'b1;
        end
        exp_lat = 4;
`ifdef SOC_CPU_MUL_SEQ_SKIP_EN
        if (b[31:16] == 16'h0) exp_lat = 3;
`endif
        // cyc numbers the cycles following the handshake edge, starting at 1.
        cyc = 1;
        while (!rsp_valid && cyc < 12) begin
            if (cyc == 1) begin
                checkOutput("busy_p0", {31'b0, busy}, 32'd1);
                checkOutput("p0_src1", M_mul_src1, a);
                checkOutput("p0_src2", M_mul_src2, {16'h0, b[15:0]});
            end
            if (cyc == 2 && exp_lat == 4) begin
                checkOutput("p1_src1", M_mul_src1, a);
                checkOutput("p1_src2", M_mul_src2, {16'h0, b[31:16]});
            end
            if (cyc == 3 && exp_lat == 4) begin
                checkOutput("p2_src1_zero", M_mul_src1, 32'h0);
            end
            tick();
            cyc++;
        end
        checkOutput("rsp_latency", 32'(cyc), 32'(exp_lat));
        exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        checkOutput("rsp_result", rsp_result, exp_res);
        checkOutput("done_src_zero", M_mul_src1 | M_mul_src2, 32'h0);
        held = rsp_result;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_src1  = $urandom;
            req_src2  = $urandom;
            tick();
            checkOutput("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("hold_rsp_result", rsp_result, held);
            checkOutput("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("after_ack_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("after_ack_busy", {31'b0, busy}, 32'd0);
        checkOutput("after_ack_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        vec_t vecs[9];
        bit   saw_valid;
        vecs[0] = '{32'h00010003, 32'h00020005, 32'h000B000F, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[2] = '{32'h00000007, 32'h00000009, 32'h0000003F, 1'b0};
        vecs[3] = '{32'h00000000, 32'h12345678, 32'h00000000, 1'b0};
        vecs[4] = '{32'h12345678, 32'h00000001, 32'h12345678, 1'b1};
        vecs[5] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[6] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0};
        vecs[7] = '{32'h00000003, 32'h80000000, 32'h80000000, 1'b1};
        vecs[8] = '{32'h12345678, 32'h00000100, 32'h34567800, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_result", rsp_result, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd0);
        reset_n = 1'b1;
        tick();
        checkOutput("req_ready_first_cycle", {31'b0, req_ready}, 32'd1);

        // rsp_ready with no response pending is ignored.
        rsp_ready = 1'b1;
        repeat (3) tick();
        rsp_ready = 1'b0;
        checkOutput("idle_ack_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("idle_ack_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp, 0, vecs[i].scramble);
        end

        // Back-pressure: response held for 10 cycles while new requests are offered.
        applyStimulus(32'h00010003, 32'h00020005, 32'h000B000F, 10, 1'b1);

        // Reset during P1 aborts the operation without a response.
        req_src1  = 32'd5;
        req_src2  = 32'h00070006;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #2;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("abort_rsp_result", rsp_result, 32'h0);
        #2;
        reset_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) saw_valid = 1'b1;
        end
        checkOutput("abort_no_rsp", {31'b0, saw_valid}, 32'd0);
        checkOutput("abort_idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_idle_req_ready", {31'b0, req_ready}, 32'd1);
        applyStimulus(32'd2, 32'd3, 32'h00000006, 0, 1'b0);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/soc_cpu_4_mul_seq.md
SOC_CPU_4_MUL_SEQ -- requirements
Module: soc_cpu_4_mul_seq

Interface
REQ-001 SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_valid  input  1  multiply request present.
REQ-005 SHALL have port: req_ready  output  1  sequencer can accept a request.
REQ-006 SHALL have port: req_src1  input  32  multiplicand A.
REQ-007 SHALL have port: req_src2  input  32  multiplier B.
REQ-008 SHALL have port: M_mul_src1  output  32  operand A to the downstream mult cell.
REQ-009 SHALL have port: M_mul_src2  output  32  operand to the mult cell; only [15:0] is meaningful.
REQ-010 SHALL have port: M_mul_cell_result  input  32  cell result, (src1*src2[15:0]) mod 2^32, valid one cycle after the operands.
REQ-011 SHALL have port: rsp_valid  output  1  result available.
REQ-012 SHALL have port: rsp_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port: rsp_result  output  32  (A*B) mod 2^32.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, P0, P1, P2 and DONE.
REQ-016 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid&req_ready at a rising edge; on a handshake, SHALL capture A and B and go to P0.
REQ-017 P0: SHALL drive M_mul_src1=A and M_mul_src2={16'h0,B[15:0]}; next state is P1.
REQ-018 P1: SHALL drive M_mul_src1=A and M_mul_src2={16'h0,B[31:16]}, and SHALL register r0=M_mul_cell_result at the end of the cycle; next state is P2.
REQ-019 P2: M_mul_cell_result equals r1; SHALL register rsp_result=(r0+(r1<<16)) mod 2^32 and go to DONE.
REQ-020 SHALL drive M_mul_src1 and M_mul_src2 as zero in IDLE, P2 and DONE.
REQ-021 DONE: SHALL hold rsp_valid=1 and rsp_result stable until rsp_ready=1 at an edge, then go to IDLE; SHALL accept no new request in that same cycle.
REQ-022 Latency: SHALL raise rsp_valid exactly 4 cycles after the handshake edge (skip disabled); throughput SHALL be at most one multiply per 5 cycles.
REQ-023 req_valid or operand changes outside IDLE SHALL be ignored; captured A and B SHALL stay constant for the whole operation.
REQ-024 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-025 The product SHALL be modulo 2^32 only; no overflow or high-word indication.

Reset
REQ-026 While reset_n=0: state=IDLE, rsp_valid=0, rsp_result=0, A=B=r0=0, busy=0, req_ready=0.
REQ-027 On reset_n deassertion, req_ready SHALL rise in the first cycle.
REQ-028 Reset asserted mid-operation SHALL abort with no response and no residual state.

Configuration
REQ-029 Macro SOC_CPU_MUL_SEQ_SKIP_EN, when defined: if B[31:16]==0, P1 SHALL register rsp_result=M_mul_cell_result directly and go to DONE, bypassing P2; rsp_valid rises 3 cycles after the handshake.
REQ-030 Without SOC_CPU_MUL_SEQ_SKIP_EN, every operation SHALL traverse P0, P1, P2 and DONE, with 4-cycle latency.

Structure
REQ-031 The state enum, the 32-bit data width and the 16-bit half width SHALL live in shared package soc_cpu_mul_pkg.
REQ-032 SHALL contain no sub-module; the mult cell is instantiated alongside it by the parent CPU.

Verification
REQ-033 SHALL cover: A=0x00010003, B=0x00020005 -> rsp_result=0x000B000F, rsp_valid 4 cycles after the handshake.
REQ-034 SHALL cover: A=B=0xFFFFFFFF -> rsp_result=0x00000001.
REQ-035 SHALL cover: A=7, B=9 with SKIP_EN defined -> 0x0000003F after 3 cycles; without SKIP_EN -> same value after 4 cycles.
REQ-036 SHALL cover: rsp_ready held low 10 cycles -> rsp_valid and rsp_result stable, req_ready=0, a new req_valid ignored; then rsp_ready=1 -> IDLE next cycle.
REQ-037 SHALL cover: reset_n pulsed low while in P1 -> rsp_valid never rises, state=IDLE; the next request A=2, B=3 -> 0x00000006.
REQ-038 SHALL cover: req_src1/req_src2 changed during P0-P2 -> result unaffected, computed from the captured operands.
